diram_phy_responder: RTL

Synthesizable DRAM-side responder for the manager DFI command/data interface. It decodes each manager's cs/cmd1/cmd0/bank/addr/data command stream and tracks the open row per bank. Writes go into an internal storage array, and read data returns on phy__dfi__valid/phy__dfi__data after a fixed latency. One instance per manager slot gives a closed-loop DRAM stand-in for manager_array bring-up at the system level.

---
 rtl/diram_phy_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/diram_phy_responder.sv
// DRAM-side responder for the manager DFI command/data interface.
// Tracks per-bank open rows with tRCD timing, stores writes in an internal
// array and returns read data after a fixed latency.
module diram_phy_responder #(
    parameter int unsigned BANK_W = 2,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned COL_W  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned TRCD   = 3
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              dfi__phy__cs,
    input  logic              dfi__phy__cmd1,
    input  logic              dfi__phy__cmd0,
    input  logic [BANK_W-1:0] dfi__phy__bank,
    input  logic [ADDR_W-1:0] dfi__phy__addr,
    input  logic [DATA_W-1:0] dfi__phy__data,
    output logic              phy__dfi__valid,
    output logic [DATA_W-1:0] phy__dfi__data,
    output logic              phy__err_no_page,
    output logic              phy__err_trcd
);

    localparam int unsigned NumBanks = 1 << BANK_W;
    localparam int unsigned MemAw    = BANK_W + ROW_W + COL_W;
    localparam int unsigned MemDepth = 1 << MemAw;
    // Counter holds cycles since ACTIVATE, never beyond TRCD-1.
    localparam int unsigned CntW     = $clog2(TRCD + 2);

    typedef enum logic [1:0] {StIdle, StRcd, StOpen} bank_st_e;

    bank_st_e         st_q  [NumBanks];
    bank_st_e         st_d  [NumBanks];
    logic [CntW-1:0]  cnt_q [NumBanks];
    logic [CntW-1:0]  cnt_d [NumBanks];
    logic [ROW_W-1:0] row_q [NumBanks];
    logic [ROW_W-1:0] row_d [NumBanks];

    logic [DATA_W-1:0] mem_q [MemDepth];

    logic [RD_LAT-1:0] pv_q;
    logic [DATA_W-1:0] pd_q [RD_LAT];

    logic              cmd_pre, cmd_act, cmd_rd, cmd_wr;
    bank_st_e          sel_st;
    logic [MemAw-1:0]  mem_idx;
    logic              wr_commit;
    logic [DATA_W-1:0] rd_word;
    logic              err_np_set, err_trcd_set;
    logic              valid_q, err_np_q, err_trcd_q;
    logic [DATA_W-1:0] data_q;
    logic              unused_addr;

    // Only the low row/column bits of the address are meaningful here.
    assign unused_addr = ^dfi__phy__addr;

    assign cmd_pre = dfi__phy__cs & ~dfi__phy__cmd1 & ~dfi__phy__cmd0;
    assign cmd_act = dfi__phy__cs & ~dfi__phy__cmd1 &  dfi__phy__cmd0;
    assign cmd_rd  = dfi__phy__cs &  dfi__phy__cmd1 & ~dfi__phy__cmd0;
    assign cmd_wr  = dfi__phy__cs &  dfi__phy__cmd1 &  dfi__phy__cmd0;

    // Per-bank state register: state, tRCD counter and open row.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            for (int b = 0; b < NumBanks; b++) begin
                st_q[b]  <= StIdle;
                cnt_q[b] <= '0;
                row_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                st_q[b]  <= st_d[b];
                cnt_q[b] <= cnt_d[b];
                row_q[b] <= row_d[b];
            end
        end
    end

    // Per-bank next state; a PRECHARGE/ACTIVATE overrides the tRCD timer.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            st_d[b]  = st_q[b];
            cnt_d[b] = cnt_q[b];
            row_d[b] = row_q[b];
            // Leave RCD one edge early so a command exactly TRCD after ACTIVATE sees OPEN.
            if (st_q[b] == StRcd) begin
                if (cnt_q[b] >= CntW'(TRCD - 1)) begin
                    st_d[b] = StOpen;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
            if (dfi__phy__bank == BANK_W'(b)) begin
                if (cmd_pre) begin
                    st_d[b] = StIdle;
                end else if (cmd_act) begin
                    st_d[b]  = (TRCD <= 1) ? StOpen : StRcd;
                    cnt_d[b] = CntW'(1);
                    row_d[b] = dfi__phy__addr[ROW_W-1:0];
                end
            end
        end
    end

    // Command decode against the addressed bank: storage access and error strobes.
    always_comb begin
        sel_st       = st_q[dfi__phy__bank];
        mem_idx      = {dfi__phy__bank, row_q[dfi__phy__bank], dfi__phy__addr[COL_W-1:0]};
        wr_commit    = cmd_wr & (sel_st != StIdle);
        err_np_set   = (cmd_rd | cmd_wr) & (sel_st == StIdle);
        err_trcd_set = (cmd_rd | cmd_wr) & (sel_st == StRcd);
        rd_word      = (sel_st == StIdle) ? '0 : mem_q[mem_idx];
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_q[mem_idx] <= dfi__phy__data;
        end
    end

    // Read data pipeline; validity is tracked separately so it can be flushed.
    always_ff @(posedge clk) begin
        pd_q[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            pd_q[i] <= pd_q[i-1];
        end
    end

    // Valid pipeline, output register and sticky error flags.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            pv_q       <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_np_q   <= 1'b0;
            err_trcd_q <= 1'b0;
        end else begin
            pv_q    <= {pv_q[RD_LAT-2:0], cmd_rd};
            valid_q <= pv_q[RD_LAT-1];
            if (pv_q[RD_LAT-1]) begin
                data_q <= pd_q[RD_LAT-1];
            end
            err_np_q   <= err_np_q | err_np_set;
            err_trcd_q <= err_trcd_q | err_trcd_set;
        end
    end

    assign phy__dfi__valid  = valid_q;
    assign phy__dfi__data   = data_q;
    assign phy__err_no_page = err_np_q;
    assign phy__err_trcd    = err_trcd_q;

endmodule
